// File: rtl/ifft_pkg.sv
// ifft_pkg: shared defaults and types for the IFFT output serializer
package ifft_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_N = 16;
  localparam int DEF_CP_LEN = 4;
  typedef enum logic [1:0] {IDLE, CP, BODY} rd_state_e;
  typedef struct packed {
    logic signed [DEF_DATA_WIDTH-1:0] re;
    logic signed [DEF_DATA_WIDTH-1:0] im;
  } cplx_t;
endpackage

// File: rtl/pingpong_frame_buf.sv
// pingpong_frame_buf: two-deep frame store with load/release bookkeeping
module pingpong_frame_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int N = 16,
  localparam int AW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  frame_release,
  input  logic [DATA_WIDTH-1:0] wr_real [0:N-1],
  input  logic [DATA_WIDTH-1:0] wr_imag [0:N-1],
  input  logic [AW-1:0]         rd_idx,
  output logic                  accept,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] rd_real,
  output logic [DATA_WIDTH-1:0] rd_imag
);
  logic wr_sel, rd_sel;
  logic [DATA_WIDTH-1:0] mem_re [0:1][0:N-1];
  logic [DATA_WIDTH-1:0] mem_im [0:1][0:N-1];
  // a full store refuses even if the reader frees a slot this same cycle
  assign accept = load && occ != 2'd2;
  assign rd_real = mem_re[rd_sel][rd_idx];
  assign rd_imag = mem_im[rd_sel][rd_idx];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mem_re[0][i] <= '0;
        mem_re[1][i] <= '0;
        mem_im[0][i] <= '0;
        mem_im[1][i] <= '0;
      end
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (accept)
        for (int i = 0; i < N; i++) begin
          mem_re[wr_sel][i] <= wr_real[i];
          mem_im[wr_sel][i] <= wr_imag[i];
        end
      wr_sel <= wr_sel ^ accept;
      rd_sel <= rd_sel ^ frame_release;
      occ <= occ + {1'b0, accept} - {1'b0, frame_release};
    end
  end
endmodule

// File: rtl/ifft_cp_serializer.sv
// ifft_cp_serializer: captures parallel IFFT frames and streams them with a cyclic prefix
module ifft_cp_serializer
  import ifft_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N = DEF_N,
  parameter int CP_LEN = DEF_CP_LEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_load,
  input  logic [DATA_WIDTH-1:0] frame_real [0:N-1],
  input  logic [DATA_WIDTH-1:0] frame_imag [0:N-1],
  output logic                  load_ready,
  output logic [DATA_WIDTH-1:0] sample_real,
  output logic [DATA_WIDTH-1:0] sample_imag,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  sample_cp,
  output logic                  sample_last,
  output logic                  frame_drop,
  output logic [7:0]            drop_count
);
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [AW-1:0] START_IDX = AW'(N - CP_LEN);
  localparam rd_state_e START_ST = (CP_LEN == 0) ? BODY : CP;
  rd_state_e state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic [1:0] occ;
  logic accept, rel, beat, wrap, next_busy;
  pingpong_frame_buf #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_buf (
    .clk(clk),
    .reset(reset),
    .load(frame_load),
    .frame_release(rel),
    .wr_real(frame_real),
    .wr_imag(frame_imag),
    .rd_idx(idx),
    .accept(accept),
    .occ(occ),
    .rd_real(sample_real),
    .rd_imag(sample_imag)
  );
  assign beat = sample_valid && sample_ready;
  assign wrap = beat && idx == LAST;
  assign rel = wrap && state == BODY;
  // another frame is waiting after this release, counting a load landing now
  assign next_busy = occ == 2'd2 || accept;
  assign load_ready = occ != 2'd2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
    end
  end
  always_comb begin
    state_n = state;
    idx_n = beat ? idx + 1'b1 : idx;
    case (state)
      IDLE: begin
        state_n = occ != 2'd0 ? START_ST : IDLE;
        idx_n = START_IDX;
      end
      CP: state_n = wrap ? BODY : CP;
      BODY: begin
        state_n = !rel ? BODY : next_busy ? START_ST : IDLE;
        if (rel) idx_n = START_IDX;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    sample_valid = state != IDLE;
    sample_cp = state == CP;
    sample_last = state == BODY && idx == LAST;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_drop <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      frame_drop <= frame_load && !accept;
      if (frame_load && !accept && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_ifft_cp_serializer.sv
// tb_ifft_cp_serializer: randomized scoreboard bench for the cyclic-prefix serializer
module tb_ifft_cp_serializer;
  import ifft_pkg::*;
  localparam int N = DEF_N;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int CPL = DEF_CP_LEN;
  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic cp;
    logic last;
    logic first;
  } beat_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_load = 1'b0;
  logic load0 = 1'b0;
  logic sample_ready = 1'b1;
  logic [DW-1:0] frame_real [0:N-1];
  logic [DW-1:0] frame_imag [0:N-1];
  logic load_ready, sample_valid, sample_cp, sample_last, frame_drop;
  logic [DW-1:0] sample_real, sample_imag;
  logic [7:0] drop_count;
  logic load_ready0, valid0, cp0, last0, drop0;
  logic [DW-1:0] real0, imag0;
  logic [7:0] count0;
  beat_t q[$];
  int fr = 0;
  int exp_cnt = 0;
  bit exp_drop = 0;
  bit b2b = 0;
  int n_beats = 0;
  int n_chk = 0;
  int n_pass = 0;

  ifft_cp_serializer #(.DATA_WIDTH(DW), .N(N), .CP_LEN(CPL)) u_dut (
    .clk(clk), .reset(reset), .frame_load(frame_load),
    .frame_real(frame_real), .frame_imag(frame_imag), .load_ready(load_ready),
    .sample_real(sample_real), .sample_imag(sample_imag), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sample_cp(sample_cp), .sample_last(sample_last),
    .frame_drop(frame_drop), .drop_count(drop_count)
  );

  ifft_cp_serializer #(.DATA_WIDTH(DW), .N(N), .CP_LEN(0)) u_dut0 (
    .clk(clk), .reset(reset), .frame_load(load0),
    .frame_real(frame_real), .frame_imag(frame_imag), .load_ready(load_ready0),
    .sample_real(real0), .sample_imag(imag0), .sample_valid(valid0),
    .sample_ready(1'b1), .sample_cp(cp0), .sample_last(last0),
    .frame_drop(drop0), .drop_count(count0)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // reference model: a queue of every beat owed to the consumer, in order
  always @(negedge clk) begin
    bit refuse, acc;
    beat_t b;
    int s;
    if (reset) begin
      q.delete();
      fr = 0;
      exp_drop = 0;
      exp_cnt = 0;
    end else begin
      refuse = frame_load && fr == 2;
      acc = frame_load && fr < 2;
      chk("load_ready", 16'(load_ready), 16'(fr < 2));
      chk("frame_drop", 16'(frame_drop), 16'(exp_drop));
      chk("drop_count", 16'(drop_count), 16'(exp_cnt));
      if (sample_valid && q.size() == 0) chk("spurious_valid", 16'(sample_valid), 16'd0);
      else if (sample_valid) begin
        chk("real", sample_real, q[0].re);
        chk("imag", sample_imag, q[0].im);
        chk("cp", 16'(sample_cp), 16'(q[0].cp));
        chk("last", 16'(sample_last), 16'(q[0].last));
        if (sample_ready) begin
          if (q[0].last) fr--;
          void'(q.pop_front());
          n_beats++;
        end
      end else if (q.size() != 0 && (!q[0].first || b2b))
        chk("valid_gap", 16'(sample_valid), 16'd1);
      if (acc) begin
        for (int k = 0; k < N + CPL; k++) begin
          s = k < CPL ? N - CPL + k : k - CPL;
          b.re = frame_real[s];
          b.im = frame_imag[s];
          b.cp = k < CPL;
          b.last = k == N + CPL - 1;
          b.first = k == 0;
          q.push_back(b);
        end
        fr++;
      end
      exp_drop = refuse;
      if (refuse && exp_cnt < 255) exp_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp(input int base);
    for (int i = 0; i < N; i++) begin
      frame_real[i] = 16'(base + i);
      frame_imag[i] = 16'(-(base + i));
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < N; i++) begin
      frame_real[i] = 16'($urandom);
      frame_imag[i] = 16'($urandom);
    end
  endtask

  task automatic pulse_load();
    frame_load = 1'b1;
    step();
    frame_load = 1'b0;
  endtask

  task automatic drain(input int budget, input bit rnd);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      if (rnd) sample_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    sample_ready = 1'b1;
    if (q.size() != 0) chk("drain_timeout", 16'(q.size()), 16'd0);
  endtask

  initial begin
    int b0, k;
    for (int i = 0; i < N; i++) begin
      frame_real[i] = '0;
      frame_imag[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", 16'(sample_valid), 16'd0);
    chk("rst_cp", 16'(sample_cp), 16'd0);
    chk("rst_last", 16'(sample_last), 16'd0);
    chk("rst_drop", 16'(frame_drop), 16'd0);
    chk("rst_count", 16'(drop_count), 16'd0);
    chk("rst_ready", 16'(load_ready), 16'd1);
    chk("rst_real", sample_real, 16'd0);
    chk("rst_imag", sample_imag, 16'd0);
    // single ramp frame with latency check
    set_ramp(0);
    pulse_load();
    @(negedge clk) chk("lat_e0", 16'(sample_valid), 16'd0);
    @(negedge clk) chk("lat_e1", 16'(sample_valid), 16'd1);
    drain(200, 0);
    // same frame under random backpressure
    step();
    set_ramp(0);
    pulse_load();
    drain(400, 1);
    // two frames four cycles apart must stream without a gap
    set_ramp(0);
    pulse_load();
    repeat (3) step();
    set_ramp(100);
    pulse_load();
    b2b = 1;
    drain(200, 0);
    b2b = 0;
    // overflow with the consumer stalled, then saturation
    sample_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rand();
      pulse_load();
    end
    frame_load = 1'b1;
    repeat (300) step();
    frame_load = 1'b0;
    step();
    chk("drop_sat", 16'(drop_count), 16'd255);
    drain(400, 1);
    // random traffic
    for (int c = 0; c < 400; c++) begin
      frame_load = $urandom_range(0, 9) == 0;
      set_rand();
      sample_ready = $urandom_range(0, 3) != 0;
      step();
    end
    frame_load = 1'b0;
    drain(400, 1);
    // reset at beat 7 with a second frame buffered
    sample_ready = 1'b1;
    set_ramp(0);
    pulse_load();
    set_ramp(100);
    pulse_load();
    b0 = n_beats;
    k = 0;
    while (n_beats - b0 < 7 && k < 100) begin
      step();
      k++;
    end
    if (n_beats - b0 < 7) chk("beat7_timeout", 16'(n_beats - b0), 16'd7);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 16'(sample_valid), 16'd0);
    chk("arst_ready", 16'(load_ready), 16'd1);
    chk("arst_count", 16'(drop_count), 16'd0);
    chk("arst_cp", 16'(sample_cp), 16'd0);
    chk("arst_real", sample_real, 16'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_after_rst", 16'(sample_valid), 16'd0);
    end
    set_ramp(200);
    pulse_load();
    drain(200, 0);
    // zero-length prefix instance
    set_ramp(0);
    load0 = 1'b1;
    step();
    load0 = 1'b0;
    @(negedge clk) chk("cp0_lat", 16'(valid0), 16'd0);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("cp0_valid", 16'(valid0), 16'd1);
      chk("cp0_real", real0, 16'(i));
      chk("cp0_imag", imag0, 16'(-i));
      chk("cp0_cp", 16'(cp0), 16'd0);
      chk("cp0_last", 16'(last0), 16'(i == N - 1));
    end
    @(negedge clk) chk("cp0_end", 16'(valid0), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
